// File: rtl/key_event_gen.sv
// Keypad key-event front end: debounces the 16-bit scan vector, rejects chords
// and emits one valid/ack-handshaked key code per physical press.
module key_event_gen #(
  parameter int unsigned STABLE_CYCLES = 100_000,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic [15:0] keys,
  input  logic        key_ack,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_multi,
  output logic        key_overrun
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  state_t            state, state_n;
  logic [15:0]       cand, cand_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              valid_n;
  logic [3:0]        code_n;
  logic              overrun_n;
  logic              any_key;
  logic              one_hot;
  logic              fire;

  function automatic logic [3:0] bit_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  assign any_key   = |keys;
  assign one_hot   = any_key && ((keys & (keys - 16'd1)) == '0);
  assign key_multi = (state == IDLE) && any_key && !one_hot;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state       <= IDLE;
      cand        <= '0;
      cnt         <= '0;
      key_valid   <= 1'b0;
      key_code    <= '0;
      key_overrun <= 1'b0;
    end else begin
      state       <= state_n;
      cand        <= cand_n;
      cnt         <= cnt_n;
      key_valid   <= valid_n;
      key_code    <= code_n;
      key_overrun <= overrun_n;
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    fire    = 1'b0;

    unique case (state)
      IDLE: begin
        if (one_hot) begin
          cand_n  = keys;
          cnt_n   = CNT_W'(1);
          state_n = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (keys != cand) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt == CNT_MAX) begin
          fire    = 1'b1;
          cnt_n   = '0;
          state_n = HELD;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HELD: begin
        if (any_key) begin
          cnt_n = '0;
        end else if (cnt == CNT_MAX) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // A new event always wins; it only counts as overrun if the old one went unacked.
  always_comb begin
    valid_n   = key_valid;
    code_n    = key_code;
    overrun_n = 1'b0;
    if (fire) begin
      valid_n   = 1'b1;
      code_n    = bit_index(cand);
      overrun_n = key_valid && !key_ack;
    end else if (key_valid && key_ack) begin
      valid_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen with STABLE_CYCLES=4; expectations are
// hand-derived cycle counts from the press/release/handshake behaviour.
module tb_key_event_gen;

  logic        clk;
  logic        rst_l;
  logic [15:0] keys;
  logic        key_ack;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_multi;
  logic        key_overrun;

  int checks;
  int errors;

  key_event_gen #(.STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .keys       (keys),
    .key_ack    (key_ack),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_multi  (key_multi),
    .key_overrun(key_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [3:0] c, input logic o);
    check({tag, "_valid"}, 16'(key_valid), 16'(v));
    check({tag, "_code"}, 16'(key_code), 16'(c));
    check({tag, "_overrun"}, 16'(key_overrun), 16'(o));
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_l   = 1'b0;
    keys    = 16'h0008;
    key_ack = 1'b0;

    // reset held with a key pressed
    tick(3);
    check_out("reset", 1'b0, 4'd0, 1'b0);
    check("reset_multi", 16'(key_multi), 16'd0);

    // release reset: event after 4 samples, code 3
    rst_l = 1'b1;
    tick(3);
    check("press_early", 16'(key_valid), 16'd0);
    tick(1);
    check_out("press", 1'b1, 4'd3, 1'b0);
    tick(6);
    check_out("press_hold", 1'b1, 4'd3, 1'b0);

    // ack pulse
    key_ack = 1'b1;
    tick(1);
    key_ack = 1'b0;
    check_out("ack", 1'b0, 4'd3, 1'b0);
    key_ack = 1'b1;
    tick(1);
    key_ack = 1'b0;
    check_out("ack_idle_ignored", 1'b0, 4'd3, 1'b0);

    // bounce during release: 0 x3, key x1, then 0 x4 back to IDLE
    keys = 16'h0000;
    tick(3);
    keys = 16'h0008;
    tick(1);
    keys = 16'h0000;
    tick(3);
    keys = 16'h0003;
    #1;
    check("release_not_idle_yet_multi", 16'(key_multi), 16'd0);
    keys = 16'h0000;
    tick(1);
    check_out("release_bounce", 1'b0, 4'd3, 1'b0);

    // chord in IDLE
    keys = 16'h0003;
    #1;
    check("chord_multi", 16'(key_multi), 16'd1);
    tick(5);
    check("chord_multi_hold", 16'(key_multi), 16'd1);
    check_out("chord_no_event", 1'b0, 4'd3, 1'b0);
    keys = 16'h0002;
    #1;
    check("chord_single_multi", 16'(key_multi), 16'd0);
    tick(3);
    check("chord_single_early", 16'(key_valid), 16'd0);
    tick(1);
    check_out("chord_single", 1'b1, 4'd1, 1'b0);
    keys = 16'h0003;
    #1;
    check("held_multi_zero", 16'(key_multi), 16'd0);
    tick(1);
    key_ack = 1'b1;
    tick(1);
    key_ack = 1'b0;
    check_out("chord_ack", 1'b0, 4'd1, 1'b0);

    // press bounce: 3 samples, 1 zero, then stable
    keys = 16'h0000;
    tick(4);
    keys = 16'h0008;
    tick(3);
    keys = 16'h0000;
    tick(1);
    keys = 16'h0008;
    tick(3);
    check("bounce_early", 16'(key_valid), 16'd0);
    tick(1);
    check_out("bounce_event", 1'b1, 4'd3, 1'b0);
    key_ack = 1'b1;
    tick(1);
    key_ack = 1'b0;

    // long hold: one event only
    keys = 16'h0000;
    tick(4);
    keys = 16'h0400;
    tick(4);
    check_out("hold_event", 1'b1, 4'd10, 1'b0);
    key_ack = 1'b1;
    tick(1);
    key_ack = 1'b0;
    tick(95);
    check_out("hold_no_repeat", 1'b0, 4'd10, 1'b0);

    // re-press after full release
    keys = 16'h0000;
    tick(4);
    keys = 16'h8000;
    tick(3);
    check("repress_early", 16'(key_valid), 16'd0);
    tick(1);
    check_out("repress", 1'b1, 4'd15, 1'b0);

    // overrun chain without ack: 15 -> 2 -> 7
    keys = 16'h0000;
    tick(4);
    keys = 16'h0004;
    tick(4);
    check_out("overrun_2", 1'b1, 4'd2, 1'b1);
    tick(1);
    check_out("overrun_2_pulse_end", 1'b1, 4'd2, 1'b0);
    keys = 16'h0000;
    tick(4);
    keys = 16'h0080;
    tick(4);
    check_out("overrun_7", 1'b1, 4'd7, 1'b1);
    tick(1);
    check_out("overrun_7_pulse_end", 1'b1, 4'd7, 1'b0);

    // ack on the same edge as a new event
    keys = 16'h0000;
    tick(4);
    keys = 16'h0200;
    tick(3);
    key_ack = 1'b1;
    tick(1);
    check_out("ack_same_edge", 1'b1, 4'd9, 1'b0);
    tick(1);
    key_ack = 1'b0;
    check_out("ack_after_same_edge", 1'b0, 4'd9, 1'b0);

    // reset pulse mid-debounce
    keys = 16'h0000;
    tick(4);
    keys = 16'h0020;
    tick(2);
    rst_l = 1'b0;
    #2;
    check_out("midreset_async", 1'b0, 4'd0, 1'b0);
    tick(1);
    rst_l = 1'b1;
    tick(3);
    check_out("midreset_no_event", 1'b0, 4'd0, 1'b0);
    tick(1);
    check_out("midreset_fresh", 1'b1, 4'd5, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
